set_assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-through, write-allocate data cache with true-LRU replacement, one 32-bit word per line. Sits between the pipeline's MEM stage and the main-memory controller and replaces the fixed 128-set single-way lab cache. It adds configurable ways and sets, a request/done handshake, and a post-reset invalidation sweep.

---
 rtl/cache_pkg.sv | 19 +
 rtl/lru_ages.sv | 44 ++++
 rtl/set_assoc_cache.sv | 169 ++++++++++++++++
 tb/tb_set_assoc_cache.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative data cache.
package cache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_LOOKUP, S_MISS, S_WRITE, S_RESP
  } state_t;

  function automatic bit ways_legal(input int w);
    return (w == 1) || (w == 2) || (w == 4);
  endfunction

  // Width of a way index / age field; never zero so WAYS=1 still has a bit.
  function automatic int way_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/lru_ages.sv
// True-LRU age tracker: one age per way per set, 0 = MRU, WAYS-1 = victim.
module lru_ages
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 128,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic                     clk,
  input  logic                     i_flush,
  input  logic [IDX_W-1:0]         i_flush_idx,
  input  logic                     i_touch,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic [way_w(WAYS)-1:0]   i_touch_way,
  output logic [way_w(WAYS)-1:0]   o_victim
);
  localparam int AW = way_w(WAYS);

  logic [AW-1:0] r_age [SETS][WAYS];
  logic [AW-1:0] w_old;

  assign w_old = r_age[i_idx][i_touch_way];

  always_ff @(posedge clk) begin
    if (i_flush) begin
      for (int w = 0; w < WAYS; w++) r_age[i_flush_idx][w] <= AW'(w);
    end else if (i_touch) begin
      // Only ways younger than the touched one age; the rest keep their order.
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == i_touch_way)
          r_age[i_idx][w] <= '0;
        else if (r_age[i_idx][w] < w_old)
          r_age[i_idx][w] <= r_age[i_idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    o_victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (r_age[i_idx][w] == AW'(WAYS - 1)) o_victim = AW'(w);
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way write-through, write-allocate data cache, one word per line, true LRU.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int SETS  = 128,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cache_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);
  localparam int WW = way_w(WAYS);

  if (!ways_legal(WAYS)) begin : g_bad_ways
    $error("set_assoc_cache: WAYS must be 1, 2 or 4");
  end

  logic              r_valid [WAYS][SETS];
  logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
  logic [WORD_W-1:0] r_data  [WAYS][SETS];

  state_t            r_state;
  logic [IDX_W-1:0]  r_cnt;
  logic              r_busy, r_done, r_mem_req, r_mem_we, r_wr;
  logic [31:0]       r_rdata, r_mem_addr, r_mem_wdata, r_lat;
  logic [WW-1:0]     r_way;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_any_hit, w_wr_line, w_touch, w_flush;
  logic [WW-1:0]     w_hit_way, w_victim, w_sel_way, w_line_way;
  logic [31:0]       w_line_data;
  logic              w_unused;

  assign w_idx    = cpu_addr[IDX_W+1:2];
  assign w_tag    = cpu_addr[31:IDX_W+2];
  assign w_unused = &{1'b0, cpu_addr[1:0]};

  always_comb begin
    w_any_hit = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_any_hit = 1'b1;
        w_hit_way = WW'(w);
      end
    end
  end

  // A write goes into the hit way, otherwise into the LRU victim; fills reuse the victim latched at LOOKUP.
  assign w_sel_way   = w_any_hit ? w_hit_way : w_victim;
  assign w_line_way  = (r_state == S_MISS) ? r_way : w_sel_way;
  assign w_line_data = (r_state == S_MISS) ? mem_rdata : cpu_wdata;
  assign w_wr_line   = ((r_state == S_LOOKUP) && r_wr) || ((r_state == S_MISS) && mem_ready);
  assign w_touch     = rst && (w_wr_line || ((r_state == S_LOOKUP) && !r_wr && w_any_hit));
  assign w_flush     = rst && (r_state == S_FLUSH);

  lru_ages #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W)) u_lru (
    .clk         (clk),
    .i_flush     (w_flush),
    .i_flush_idx (r_cnt),
    .i_touch     (w_touch),
    .i_idx       (w_idx),
    .i_touch_way (w_line_way),
    .o_victim    (w_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == S_FLUSH) begin
        for (int w = 0; w < WAYS; w++) r_valid[w][r_cnt] <= 1'b0;
      end else if (w_wr_line) begin
        r_valid[w_line_way][w_idx] <= 1'b1;
        r_tag[w_line_way][w_idx]   <= w_tag;
        r_data[w_line_way][w_idx]  <= w_line_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_FLUSH;
      r_cnt       <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wr        <= 1'b0;
      r_way       <= '0;
      r_lat       <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rdata <= '0;
      case (r_state)
        S_FLUSH: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == IDX_W'(SETS - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: if (cpu_we || cpu_re) begin
          r_state <= S_LOOKUP;
          r_busy  <= 1'b1;
          r_wr    <= cpu_we;
        end
        S_LOOKUP: begin
          r_mem_addr  <= {cpu_addr[31:2], 2'b00};
          r_mem_wdata <= cpu_wdata;
          if (r_wr) begin
            r_state   <= S_WRITE;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b1;
          end else if (w_any_hit) begin
            r_state <= S_RESP;
            r_lat   <= r_data[w_hit_way][w_idx];
          end else begin
            r_state   <= S_MISS;
            r_way     <= w_victim;
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b0;
          end
        end
        S_MISS: if (mem_ready) begin
          r_state   <= S_RESP;
          r_lat     <= mem_rdata;
          r_mem_req <= 1'b0;
        end
        S_WRITE: if (mem_ready) begin
          r_state   <= S_RESP;
          r_mem_req <= 1'b0;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_rdata <= r_wr ? '0 : r_lat;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_FLUSH;
      endcase
    end
  end

  assign cpu_rdata  = r_rdata;
  assign cpu_done   = r_done;
  assign cache_busy = r_busy;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache with default parameters (2 ways, 128 sets).
module tb_set_assoc_cache;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cache_busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  set_assoc_cache dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cache_busy(cache_busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one request; memory answers with mem_ready after mem_req has been high k cycles.
  task automatic xact(input logic re, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input int k, input logic [31:0] md,
                      output int lat, output logic saw, output logic swe,
                      output logic [31:0] sa, output logic [31:0] sw,
                      output logic [31:0] rd, output logic dn, output logic mreq_end);
    int n, rc;
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    n = 0; rc = 0; saw = 1'b0; swe = 1'b0; sa = '0; sw = '0;
    do begin
      @(posedge clk); #1;
      n++;
      mem_ready = 1'b0;
      if (mem_req) begin
        if (!saw) begin swe = mem_we; sa = mem_addr; sw = mem_wdata; end
        saw = 1'b1;
        rc++;
        if (rc == k + 1) begin mem_ready = 1'b1; mem_rdata = md; end
      end
    end while (!cpu_done && n < 100);
    lat = n - 1; rd = cpu_rdata; dn = cpu_done; mreq_end = mem_req;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic wait_flush(input int start, output int n);
    n = start;
    while (cache_busy && n < 300) begin @(posedge clk); #1; n++; end
  endtask

  int lat, n;
  logic saw, swe, dn, mreq_end;
  logic [31:0] sa, sw, rd;

  initial begin
    // Reset and flush sweep
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, cache_busy}, 32'd1);
    chk("rst_outs", {cpu_rdata | mem_addr | mem_wdata}, 32'd0);
    chk("rst_flags", {28'd0, cpu_done, mem_req, mem_we, 1'b0}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("flush_mid_outs", {29'd0, cpu_done, mem_req, mem_we}, 32'd0);
    wait_flush(1, n);
    chk("flush_len", n, 32'd128);
    chk("idle_busy", {31'd0, cache_busy}, 32'd0);

    // Read miss with 4-cycle memory, then a repeat hit
    xact(1, 0, 32'h0000_0100, 32'h0, 4, 32'hDEAD_BEEF, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("miss_done", {31'd0, dn}, 32'd1);
    chk("miss_data", rd, 32'hDEAD_BEEF);
    chk("miss_lat", lat, 32'd7);
    chk("miss_req", {30'd0, saw, swe}, 32'd2);
    chk("miss_addr", sa, 32'h0000_0100);
    chk("miss_req_drop", {31'd0, mreq_end}, 32'd0);
    xact(1, 0, 32'h0000_0100, 32'h0, 4, 32'h0, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("hit_data", rd, 32'hDEAD_BEEF);
    chk("hit_lat", lat, 32'd2);
    chk("hit_noreq", {31'd0, saw}, 32'd0);

    // Write-through then read hit
    xact(0, 1, 32'h0000_0040, 32'h1234_5678, 2, 32'h0, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("wr_req", {30'd0, saw, swe}, 32'd3);
    chk("wr_addr", sa, 32'h0000_0040);
    chk("wr_wdata", sw, 32'h1234_5678);
    chk("wr_lat", lat, 32'd5);
    chk("wr_rdata", rd, 32'd0);
    xact(1, 0, 32'h0000_0040, 32'h0, 2, 32'h0, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("wr_rd_data", rd, 32'h1234_5678);
    chk("wr_rd_hit", {31'd0, saw}, 32'd0);

    // Same-set pressure: 0x000 becomes LRU and is evicted by 0x400
    xact(0, 1, 32'h0000_0000, 32'hAAAA_0000, 1, 32'h0, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    xact(0, 1, 32'h0000_0200, 32'hBBBB_0200, 1, 32'h0, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    xact(0, 1, 32'h0000_0400, 32'hCCCC_0400, 1, 32'h0, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("set_wr_lat", lat, 32'd4);
    xact(1, 0, 32'h0000_0200, 32'h0, 1, 32'h0, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("lru_hit_data", rd, 32'hBBBB_0200);
    chk("lru_hit_noreq", {31'd0, saw}, 32'd0);
    xact(1, 0, 32'h0000_0000, 32'h0, 1, 32'h5555_0000, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("lru_evict_miss", {31'd0, saw}, 32'd1);
    chk("lru_evict_data", rd, 32'h5555_0000);
    chk("lru_evict_lat", lat, 32'd4);

    // Read and write together is a write
    xact(1, 1, 32'h0000_0080, 32'h0000_0077, 1, 32'hFFFF_FFFF, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("both_we", {30'd0, saw, swe}, 32'd3);
    chk("both_rdata", rd, 32'd0);
    xact(1, 0, 32'h0000_0080, 32'h0, 1, 32'h0, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("both_rd_data", rd, 32'h0000_0077);

    // Reset during a miss wait
    cpu_re = 1'b1; cpu_addr = 32'h0000_0300;
    n = 0;
    while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
    chk("abort_req_seen", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_req_drop", {31'd0, mem_req}, 32'd0);
    chk("abort_busy", {31'd0, cache_busy}, 32'd1);
    cpu_re = 1'b0;
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    wait_flush(1, n);
    chk("reflush_len", n, 32'd128);
    chk("reflush_done", {31'd0, cpu_done}, 32'd0);
    xact(1, 0, 32'h0000_0100, 32'h0, 2, 32'hCAFE_0001, lat, saw, swe, sa, sw, rd, dn, mreq_end);
    chk("post_rst_miss", {31'd0, saw}, 32'd1);
    chk("post_rst_data", rd, 32'hCAFE_0001);
    chk("post_rst_lat", lat, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
